// File: rtl/ni_flit_injector.sv
// Credit-based wormhole flit injector for an NI endpoint: turns packet requests plus
// streamed payload words into header/body/tail flits on a round-robin chosen VC.
module ni_flit_injector #(
    parameter int V = 4,
    parameter int B = 4,
    parameter int Fpay = 32,
    parameter int EAw = 8,
    parameter int C = 2,
    parameter logic [C*V-1:0] CLASS_SETTING = '1,
    parameter int PCKw = 8,
    localparam int Fw = 2 + V + Fpay,
    localparam int Cw = (C > 1) ? $clog2(C) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [EAw-1:0]  current_e_addr,
    input  logic            pck_valid,
    output logic            pck_ready,
    input  logic [EAw-1:0]  pck_dest,
    input  logic [Cw-1:0]   pck_class,
    input  logic [PCKw-1:0] pck_size,
    input  logic            data_valid,
    output logic            data_ready,
    input  logic [Fpay-1:0] data_in,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    output logic            credit_err
);

    localparam int CntW = $clog2(B + 1);
    localparam int VW = (V > 1) ? $clog2(V) : 1;
    localparam int unsigned NV = V;
    localparam int unsigned NC = C;

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t          state, state_next;
    logic [EAw-1:0]  dest_r;
    logic [Cw-1:0]   class_r;
    logic [PCKw-1:0] size_r;
    logic [PCKw-1:0] remaining, remaining_next;
    logic [VW-1:0]   cur_vc, cur_vc_next;
    logic [VW-1:0]   rr_ptr, rr_ptr_next;
    logic [CntW-1:0] credit [V];

    logic [V-1:0]    has_credit;
    logic [V-1:0]    class_mask;
    logic [V-1:0]    eligible;
    logic            found;
    logic [VW-1:0]   pick;
    logic [VW-1:0]   idx;
    logic [VW-1:0]   vc_sel;
    logic [V-1:0]    vc_oh;
    logic [V-1:0]    send_oh;
    logic            send;
    logic [Fpay-1:0] hdr_payload;
    logic [Fw-1:0]   flit_next;

    always_comb begin
        has_credit = '0;
        for (int unsigned v = 0; v < NV; v++) begin
            has_credit[v] = (credit[v] != '0);
        end
    end

    always_comb begin
        class_mask = '0;
        for (int unsigned c = 0; c < NC; c++) begin
            if (class_r == Cw'(c)) class_mask = CLASS_SETTING[c*V +: V];
        end
    end

    assign eligible = class_mask & has_credit;

    // First eligible VC at or after the round-robin pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NV; i++) begin
            idx = VW'((32'(rr_ptr) + i) % NV);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        hdr_payload = '0;
        hdr_payload[EAw-1:0]     = current_e_addr;
        hdr_payload[2*EAw-1:EAw] = dest_r;
        hdr_payload[2*EAw +: Cw] = class_r;
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        cur_vc_next    = cur_vc;
        rr_ptr_next    = rr_ptr;
        send           = 1'b0;
        flit_next      = '0;
        pck_ready      = (state == IDLE);
        data_ready     = 1'b0;
        vc_sel         = (state == HEAD) ? pick : cur_vc;
        vc_oh          = '0;
        vc_oh[vc_sel]  = 1'b1;

        case (state)
            IDLE: begin
                if (pck_valid) state_next = HEAD;
            end
            HEAD: begin
                if (found) begin
                    send           = 1'b1;
                    cur_vc_next    = pick;
                    rr_ptr_next    = (pick == VW'(V - 1)) ? '0 : pick + VW'(1);
                    flit_next      = {1'b1, size_r == PCKw'(1), vc_oh, hdr_payload};
                    remaining_next = size_r - PCKw'(1);
                    state_next     = (size_r == PCKw'(1)) ? IDLE : BODY;
                end
            end
            BODY: begin
                data_ready = has_credit[cur_vc];
                if (data_valid && data_ready) begin
                    send           = 1'b1;
                    flit_next      = {1'b0, remaining == PCKw'(1), vc_oh, data_in};
                    remaining_next = remaining - PCKw'(1);
                    if (remaining == PCKw'(1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        send_oh = send ? vc_oh : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dest_r      <= '0;
            class_r     <= '0;
            size_r      <= '0;
            remaining   <= '0;
            cur_vc      <= '0;
            rr_ptr      <= '0;
            flit_out    <= '0;
            flit_out_wr <= 1'b0;
            credit_err  <= 1'b0;
            for (int unsigned v = 0; v < NV; v++) begin
                credit[v] <= CntW'(B);
            end
        end else begin
            state       <= state_next;
            remaining   <= remaining_next;
            cur_vc      <= cur_vc_next;
            rr_ptr      <= rr_ptr_next;
            flit_out_wr <= send;
            if (send) flit_out <= flit_next;
            if (state == IDLE && pck_valid) begin
                dest_r  <= pck_dest;
                class_r <= pck_class;
                size_r  <= (pck_size == '0) ? PCKw'(1) : pck_size;
            end
            // Send and return on the same VC cancel; a return at full count is an overflow.
            for (int unsigned v = 0; v < NV; v++) begin
                case ({send_oh[v], credit_in[v]})
                    2'b10: credit[v] <= credit[v] - CntW'(1);
                    2'b01: begin
                        if (credit[v] == CntW'(B)) credit_err <= 1'b1;
                        else credit[v] <= credit[v] + CntW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ni_flit_injector.sv
// Scoreboard bench for ni_flit_injector: expected flits are queued when a request is
// driven and compared in order as the injector strobes them out.
module tb_ni_flit_injector;

    localparam int V = 4;
    localparam int B = 4;
    localparam int FPAY = 32;
    localparam int EAW = 8;
    localparam int C = 2;
    localparam int PCKW = 8;
    localparam int FW = 2 + V + FPAY;
    localparam int CW = 1;
    // Class 0 may use VC0/VC1 only, class 1 may use all VCs.
    localparam logic [C*V-1:0] CLASS_SET = 8'b1111_0011;
    localparam logic [EAW-1:0] SRC = 8'h05;

    logic            clk;
    logic            reset;
    logic [EAW-1:0]  current_e_addr;
    logic            pck_valid;
    logic            pck_ready;
    logic [EAW-1:0]  pck_dest;
    logic [CW-1:0]   pck_class;
    logic [PCKW-1:0] pck_size;
    logic            data_valid;
    logic            data_ready;
    logic [FPAY-1:0] data_in;
    logic [FW-1:0]   flit_out;
    logic            flit_out_wr;
    logic [V-1:0]    credit_in;
    logic            credit_err;

    ni_flit_injector #(
        .V(V), .B(B), .Fpay(FPAY), .EAw(EAW), .C(C),
        .CLASS_SETTING(CLASS_SET), .PCKw(PCKW)
    ) dut (
        .clk(clk), .reset(reset), .current_e_addr(current_e_addr),
        .pck_valid(pck_valid), .pck_ready(pck_ready), .pck_dest(pck_dest),
        .pck_class(pck_class), .pck_size(pck_size),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_out(flit_out), .flit_out_wr(flit_out_wr),
        .credit_in(credit_in), .credit_err(credit_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nflits = 0;
    int acc_cyc = 0;
    int flit_t[$];
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] last_flit = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && flit_out_wr) begin
            nflits++;
            flit_t.push_back(cyc);
            last_flit = flit_out;
            if (exp_q.size() == 0) check("unexpected_flit", flit_out_wr, 1'b0);
            else check("flit", flit_out, exp_q.pop_front());
        end
    end

    function automatic logic [FW-1:0] mk_flit(input bit head, input bit tail, input int vc,
                                             input logic [FPAY-1:0] pay);
        logic [V-1:0] oh;
        oh = '0;
        oh[vc] = 1'b1;
        return {head, tail, oh, pay};
    endfunction

    function automatic logic [FPAY-1:0] mk_hdr(input logic [EAW-1:0] dest, input int cls);
        logic [FPAY-1:0] h;
        h = '0;
        h[7:0] = SRC;
        h[15:8] = dest;
        h[16] = cls[0];
        return h;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        pck_valid = 1'b0;
        data_valid = 1'b0;
        credit_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        flit_t.delete();
        nflits = 0;
    endtask

    task automatic send_pkt(input logic [EAW-1:0] dest, input int cls, input int size,
                            input int vc, input logic [FPAY-1:0] base, input int budget);
        int eff;
        int n;
        int sent;
        bit ok;
        eff = (size == 0) ? 1 : size;
        exp_q.push_back(mk_flit(1'b1, eff == 1, vc, mk_hdr(dest, cls)));
        for (int k = 1; k < eff; k++) exp_q.push_back(mk_flit(1'b0, k == eff - 1, vc, base + FPAY'(k - 1)));
        @(posedge clk);
        #1;
        pck_valid = 1'b1;
        pck_dest = dest;
        pck_class = CW'(cls);
        pck_size = PCKW'(size);
        data_valid = (eff > 1);
        data_in = base;
        n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            ok = pck_ready;
            @(posedge clk);
            n++;
        end
        #1;
        acc_cyc = cyc;
        pck_valid = 1'b0;
        if (!ok) check("accept_timeout", ok, 1'b1);
        sent = 0;
        while (sent < eff - 1 && n < budget) begin
            @(negedge clk);
            ok = data_ready;
            @(posedge clk);
            n++;
            if (ok) begin
                sent++;
                #1;
                data_in = base + FPAY'(sent);
                if (sent == eff - 1) data_valid = 1'b0;
            end
        end
        if (sent < eff - 1) check("data_timeout", sent, eff - 1);
    endtask

    task automatic wait_flits(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (nflits < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, nflits, n);
    endtask

    task automatic give_credit(input int vc, output int c0);
        @(posedge clk);
        #1;
        credit_in = '0;
        credit_in[vc] = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1 credit_in = '0;
    endtask

    task automatic pkt1(input logic [EAW-1:0] dest, input int cls, input int vc);
        int n0;
        int dummy;
        n0 = nflits;
        send_pkt(dest, cls, 1, vc, '0, 50);
        wait_flits(n0 + 1, 10, "rr_flit");
        give_credit(vc, dummy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k;
        clk = 1'b0;
        reset = 1'b1;
        current_e_addr = SRC;
        pck_valid = 1'b0;
        pck_dest = '0;
        pck_class = '0;
        pck_size = '0;
        data_valid = 1'b0;
        data_in = '0;
        credit_in = '0;

        // Reset values, before any clock edge
        #3;
        check("rst_flit_out", flit_out, '0);
        check("rst_flit_wr", flit_out_wr, 1'b0);
        check("rst_credit_err", credit_err, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_pck_ready", pck_ready, 1'b1);
        do_reset();

        // Single-flit packet
        send_pkt(8'h1A, 1, 1, 0, '0, 50);
        repeat (3) @(posedge clk);
        #1;
        check("t1_nflits", nflits, 1);
        check("t1_payload", last_flit[23:0], 24'h011A05);
        check("t1_head_tail", last_flit[37:36], 2'b11);
        check("t1_vc", last_flit[35:32], 4'b0001);
        check("t1_pck_ready", pck_ready, 1'b1);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_hdr_latency", flit_t[0], acc_cyc + 1);

        // 4-flit packet, back-to-back flits
        do_reset();
        send_pkt(8'h33, 0, 4, 0, 32'hA, 50);
        repeat (3) @(posedge clk);
        #1;
        check("t2_nflits", nflits, 4);
        check("t2_hdr_latency", flit_t[0], acc_cyc + 1);
        for (int i = 1; i < 4; i++) check("t2_gap", flit_t[i] - flit_t[i-1], 1);

        // Zero-size request behaves as a single flit
        do_reset();
        send_pkt(8'h21, 1, 0, 0, '0, 50);
        wait_flits(1, 10, "t2b_size0");

        // Credit stall on a 6-flit packet
        do_reset();
        fork
            send_pkt(8'h44, 0, 6, 0, 32'h100, 200);
            begin
                wait_flits(4, 50, "t3_first4");
                repeat (3) @(posedge clk);
                #1;
                check("t3_stall_count", nflits, 4);
                check("t3_stall_ready", data_ready, 1'b0);
                check("t3_hold", flit_out, mk_flit(1'b0, 1'b0, 0, 32'h102));
                // Credit held during cycle c0 is registered at the next edge and used one edge later.
                give_credit(0, c0);
                wait_flits(5, 20, "t3_fifth");
                check("t3_resume_time", flit_t[4], c0 + 2);
                repeat (2) @(posedge clk);
                #1;
                check("t3_stall_again", data_ready, 1'b0);
                give_credit(0, c0);
                wait_flits(6, 20, "t3_tail");
            end
        join
        check("t3_sb_empty", exp_q.size(), 0);

        // Round-robin over all VCs (class 1), credits returned each time
        do_reset();
        for (int i = 0; i < 5; i++) pkt1(8'h10 + 8'(i), 1, i % 4);
        check("t4_no_err", credit_err, 1'b0);
        // Class 0 limited to VC0/VC1
        do_reset();
        for (int i = 0; i < 4; i++) pkt1(8'h20 + 8'(i), 0, i % 2);
        check("t4_sb_empty", exp_q.size(), 0);

        // Send and credit on the same VC in one cycle
        do_reset();
        fork
            send_pkt(8'h66, 0, 6, 0, 32'h200, 200);
            begin
                k = 0;
                while (nflits < 1 && k < 20) begin
                    @(negedge clk);
                    #1;
                    k++;
                end
                credit_in = 4'b0001;
                @(posedge clk);
                #1 credit_in = '0;
                repeat (8) @(posedge clk);
                #1;
                check("t5_count", nflits, 5);
                check("t5_ready", data_ready, 1'b0);
                check("t5_no_err", credit_err, 1'b0);
                give_credit(0, c0);
                wait_flits(6, 20, "t5_tail");
            end
        join

        // Extra credit at full count
        do_reset();
        give_credit(0, c0);
        check("t5_err_rise", credit_err, 1'b1);
        fork
            send_pkt(8'h67, 0, 6, 0, 32'h280, 200);
            begin
                wait_flits(4, 50, "t5_full_first4");
                repeat (5) @(posedge clk);
                #1;
                check("t5_full_count", nflits, 4);
                check("t5_err_sticky", credit_err, 1'b1);
                give_credit(0, c0);
                wait_flits(5, 20, "t5_full_fifth");
                give_credit(0, c0);
                wait_flits(6, 20, "t5_full_tail");
            end
        join
        do_reset();
        check("t5_err_cleared", credit_err, 1'b0);

        // Reset mid-packet
        exp_q.push_back(mk_flit(1'b1, 1'b0, 0, mk_hdr(8'h77, 0)));
        exp_q.push_back(mk_flit(1'b0, 1'b0, 0, 32'h300));
        @(posedge clk);
        #1;
        pck_valid = 1'b1;
        pck_dest = 8'h77;
        pck_class = '0;
        pck_size = 8'd6;
        data_valid = 1'b1;
        data_in = 32'h300;
        @(posedge clk);
        #1 pck_valid = 1'b0;
        k = 0;
        while (nflits < 2 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t6_pre_count", nflits, 2);
        reset = 1'b1;
        #1;
        check("t6_flit_out", flit_out, '0);
        check("t6_flit_wr", flit_out_wr, 1'b0);
        check("t6_data_ready", data_ready, 1'b0);
        check("t6_pck_ready", pck_ready, 1'b1);
        data_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        flit_t.delete();
        nflits = 0;
        check("t6_ready_after", pck_ready, 1'b1);
        send_pkt(8'h78, 1, 1, 0, '0, 50);
        wait_flits(1, 10, "t6_next_pkt");
        repeat (2) @(posedge clk);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ni_flit_injector.md
# ni_flit_injector

Credit-based flit transmitter for a network-interface endpoint. It sits on the NI side of a router local port, drives the port's `flit_in`/`flit_in_we`, and consumes the per-VC credits the router returns. Accepted packet requests become wormhole flit streams: a header flit followed by body and tail flits carrying streamed payload words. One output VC is chosen per packet by round-robin over the class-permitted VCs that hold credit.

## Interface
- `V`, 4: VCs per port.
- `B`, 4: buffer depth per VC at the router input, in flits; initial credit per VC.
- `Fpay`, 32: payload width. Flit width is `Fw = 2+V+Fpay`.
- `EAw`, 8: endpoint address width.
- `C`, 2: number of message classes (≥1). `Cw = (C>1) ? log2(C) : 1`.
- `CLASS_SETTING`, all ones, width `C*V`: bits `[c*V +: V]` are the permitted-VC mask for class c.
- `PCKw`, 8: packet-size field width.
- Constraint: `Fpay ≥ 2*EAw + Cw`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `current_e_addr` in EAw: own endpoint address, written into the header as the source.
- `pck_valid` in 1: packet request valid.
- `pck_ready` out 1: request accepted while high; equals `state==IDLE`.
- `pck_dest` in EAw: destination endpoint address.
- `pck_class` in Cw: message class.
- `pck_size` in PCKw: total flits including the header; 0 is treated as 1.
- `data_valid` in 1: payload word valid.
- `data_ready` out 1: payload word consumed while `data_valid & data_ready`.
- `data_in` in Fpay: payload word for a body or tail flit.
- `flit_out` out Fw: flit to the router port.
- `flit_out_wr` out 1: flit write strobe.
- `credit_in` in V: one credit return per VC per cycle.
- `credit_err` out 1: sticky credit-overflow flag.

## Operation
- **Flit format**
  - Bit `Fw-1` = head, bit `Fw-2` = tail.
  - `[Fw-3 -: V]` = one-hot VC.
  - `[Fpay-1:0]` = payload.
  - Header payload layout: `[EAw-1:0]` = src, `[2EAw-1:EAw]` = dest, `[2EAw+Cw-1:2EAw]` = class, upper bits zero.
- **Credit counters**
  - One per VC, width `log2(B+1)`, reset to B.
  - Decrement on each flit sent on that VC; increment on `credit_in[v]`.
  - Simultaneous send and credit on the same VC leaves the count unchanged.
  - A credit arriving with the count already at B (and no send) holds the count at B and sets `credit_err`; it clears only on reset.
- **FSM: IDLE → HEAD → BODY → IDLE**
  - IDLE: `pck_ready=1`. On `pck_valid`, latch dest, class and size (0→1), then go to HEAD.
  - HEAD: eligible VCs = `CLASS_SETTING` class mask & (credit≠0).
    - If none are eligible, wait (no flit).
    - Otherwise pick the first eligible VC at or after the round-robin pointer (wrapping), emit the header flit with head=1 and tail=(size==1), and set the pointer to chosen+1 mod V.
    - Set `remaining=size-1`. Go to IDLE if size==1, else BODY.
  - BODY: `data_ready = (credit[cur_vc]≠0)`.
    - Each handshake emits a flit carrying `data_in` on `cur_vc`, with head=0 and tail=(remaining==1), then decrements `remaining`.
    - After the tail flit, go to IDLE.
  - All flits of a packet use the same VC; they never interleave with another packet.
- Eligibility and `data_ready` use registered credit counts. A credit returned in cycle N is usable in cycle N+1.
- A class mask of all zeros stalls in HEAD indefinitely; this is legal behaviour, not an error.

## Timing
- **Reset values:** `flit_out=0`, `flit_out_wr=0`, `credit_err=0`, `data_ready=0`; `pck_ready=1` (IDLE); counters=B; pointer=0; `remaining=0`.
- Reset mid-packet aborts it immediately. No tail is sent; the router side is reset alongside.
- `flit_out` and `flit_out_wr` are registered. `flit_out_wr` is a one-cycle pulse per flit; `flit_out` holds its value between strobes.
- Latency: request accepted at edge N gives the header at the output after edge N+1 when credit is available. A body handshake at edge M puts the flit at the output after edge M.
- Peak throughput: one flit per cycle while credit is available. A new request can be accepted in the cycle after the tail is issued, giving a one-cycle gap per packet.
- **Stalls:** with credit 0 on `cur_vc`, `data_ready=0` and no strobe is issued. With only one credit left, exactly one flit is sent, then the block stalls.

## Test plan
- **Single-flit packet:** V=4, B=4, C=2, addr 0x05, request dest 0x1A, class 1, size 1 → one flit with head=1, tail=1, VC=0001, payload[23:0]=0x011A05; returns to IDLE; credit[0]=3.
- **4-flit packet:** data 0xA,0xB,0xC streamed back-to-back → flits head, body A, body B, tail C on consecutive cycles on one VC; credit of that VC goes 4→0.
- **Credit stall:** a 6-flit packet with no `credit_in` → 4 flits sent, then `data_ready=0`. Pulse `credit_in` on that VC at cycle T → next flit issued at T+1.
- **Round-robin:** five single-flit packets, with credits returned each time → VCs used 0,1,2,3,0. With `CLASS_SETTING` class0 mask=0011, class-0 packets alternate VC0, VC1.
- **Simultaneous events:** send and credit on the same VC in one cycle → count unchanged. Extra credit at count=4 → count stays 4 and `credit_err` rises and stays high.
- **Reset mid-packet:** assert reset during BODY → outputs at reset values within the same cycle (async); after release, `pck_ready=1` and the next packet starts at VC0.
